// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares one data-memory read/write port among NUM_LANES LSU lanes.
// One transaction is in flight at a time; lane ready is held until the lane drops its valid.
module data_mem_arbiter #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  localparam int unsigned LaneBits = $clog2(NUM_LANES)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_LANES-1:0]                lane_read_valid,
  input  logic [NUM_LANES-1:0][ADDR_BITS-1:0] lane_read_address,
  output logic [NUM_LANES-1:0]                lane_read_ready,
  output logic [NUM_LANES-1:0][DATA_BITS-1:0] lane_read_data,
  input  logic [NUM_LANES-1:0]                lane_write_valid,
  input  logic [NUM_LANES-1:0][ADDR_BITS-1:0] lane_write_address,
  input  logic [NUM_LANES-1:0][DATA_BITS-1:0] lane_write_data,
  output logic [NUM_LANES-1:0]                lane_write_ready,
  output logic                                mem_read_valid,
  output logic [ADDR_BITS-1:0]                mem_read_address,
  input  logic                                mem_read_ready,
  input  logic [DATA_BITS-1:0]                mem_read_data,
  output logic                                mem_write_valid,
  output logic [ADDR_BITS-1:0]                mem_write_address,
  output logic [DATA_BITS-1:0]                mem_write_data,
  input  logic                                mem_write_ready,
  output logic [LaneBits-1:0]                 grant_lane,
  output logic                                busy
);

  typedef enum logic [1:0] {StIdle, StReadWait, StWriteWait, StRelay} state_e;

  state_e state_q, state_d;

  logic [LaneBits-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [LaneBits-1:0]                 grant_q, grant_d;
  logic                                op_read_q, op_read_d;
  logic                                mem_read_valid_q, mem_read_valid_d;
  logic                                mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]                mem_read_address_q, mem_read_address_d;
  logic [ADDR_BITS-1:0]                mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]                mem_write_data_q, mem_write_data_d;
  logic [NUM_LANES-1:0]                lane_read_ready_q, lane_read_ready_d;
  logic [NUM_LANES-1:0]                lane_write_ready_q, lane_write_ready_d;
  logic [NUM_LANES-1:0][DATA_BITS-1:0] lane_read_data_q, lane_read_data_d;

  logic                win_found;
  logic                win_is_read;
  logic [LaneBits-1:0] win_lane;
  logic                relay_valid;

  // Scan lanes starting at rr_ptr_q; the first lane with any request wins, read before write.
  always_comb begin
    int unsigned         cand;
    logic [LaneBits-1:0] cand_lane;
    win_found   = 1'b0;
    win_is_read = 1'b0;
    win_lane    = '0;
    cand        = 0;
    cand_lane   = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_LANES) begin
        cand = cand - NUM_LANES;
      end
      cand_lane = LaneBits'(cand);
      if (!win_found && (lane_read_valid[cand_lane] || lane_write_valid[cand_lane])) begin
        win_found   = 1'b1;
        win_lane    = cand_lane;
        win_is_read = lane_read_valid[cand_lane];
      end
    end
  end

  assign relay_valid = op_read_q ? lane_read_valid[grant_q] : lane_write_valid[grant_q];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = win_is_read ? StReadWait : StWriteWait;
        end
      end
      StReadWait: begin
        if (mem_read_ready) begin
          state_d = StRelay;
        end
      end
      StWriteWait: begin
        if (mem_write_ready) begin
          state_d = StRelay;
        end
      end
      StRelay: begin
        if (!relay_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next-state logic; every output is registered
  always_comb begin
    rr_ptr_d            = rr_ptr_q;
    grant_d             = grant_q;
    op_read_d           = op_read_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    lane_read_ready_d   = lane_read_ready_q;
    lane_write_ready_d  = lane_write_ready_q;
    lane_read_data_d    = lane_read_data_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d   = win_lane;
          op_read_d = win_is_read;
          if (win_is_read) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = lane_read_address[win_lane];
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = lane_write_address[win_lane];
            mem_write_data_d    = lane_write_data[win_lane];
          end
        end
      end
      StReadWait: begin
        if (mem_read_ready) begin
          lane_read_data_d[grant_q]  = mem_read_data;
          lane_read_ready_d[grant_q] = 1'b1;
          mem_read_valid_d           = 1'b0;
        end
      end
      StWriteWait: begin
        if (mem_write_ready) begin
          lane_write_ready_d[grant_q] = 1'b1;
          mem_write_valid_d           = 1'b0;
        end
      end
      StRelay: begin
        if (!relay_valid) begin
          lane_read_ready_d  = '0;
          lane_write_ready_d = '0;
          rr_ptr_d = (grant_q == LaneBits'(NUM_LANES - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q            <= '0;
      grant_q             <= '0;
      op_read_q           <= 1'b0;
      mem_read_valid_q    <= 1'b0;
      mem_write_valid_q   <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      lane_read_ready_q   <= '0;
      lane_write_ready_q  <= '0;
      lane_read_data_q    <= '0;
    end else begin
      rr_ptr_q            <= rr_ptr_d;
      grant_q             <= grant_d;
      op_read_q           <= op_read_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      lane_read_ready_q   <= lane_read_ready_d;
      lane_write_ready_q  <= lane_write_ready_d;
      lane_read_data_q    <= lane_read_data_d;
    end
  end

  assign lane_read_ready   = lane_read_ready_q;
  assign lane_read_data    = lane_read_data_q;
  assign lane_write_ready  = lane_write_ready_q;
  assign mem_read_valid    = mem_read_valid_q;
  assign mem_read_address  = mem_read_address_q;
  assign mem_write_valid   = mem_write_valid_q;
  assign mem_write_address = mem_write_address_q;
  assign mem_write_data    = mem_write_data_q;
  assign grant_lane        = grant_q;
  assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter: lanes and memory are modelled at transaction level,
// and a round-robin reference predicts grants, memory traffic and lane responses.
module tb_data_mem_arbiter;
  localparam int N = 4;

  localparam int PhIdle  = 0;
  localparam int PhWait  = 1;
  localparam int PhRelay = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [N-1:0]      lane_read_valid, lane_read_ready, lane_write_valid, lane_write_ready;
  logic [N-1:0][7:0] lane_read_address, lane_read_data, lane_write_address, lane_write_data;
  logic              mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready, busy;
  logic [7:0]        mem_read_address, mem_read_data, mem_write_address, mem_write_data;
  logic [1:0]        grant_lane;

  data_mem_arbiter #(.NUM_LANES(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .lane_read_valid    (lane_read_valid),
    .lane_read_address  (lane_read_address),
    .lane_read_ready    (lane_read_ready),
    .lane_read_data     (lane_read_data),
    .lane_write_valid   (lane_write_valid),
    .lane_write_address (lane_write_address),
    .lane_write_data    (lane_write_data),
    .lane_write_ready   (lane_write_ready),
    .mem_read_valid     (mem_read_valid),
    .mem_read_address   (mem_read_address),
    .mem_read_ready     (mem_read_ready),
    .mem_read_data      (mem_read_data),
    .mem_write_valid    (mem_write_valid),
    .mem_write_address  (mem_write_address),
    .mem_write_data     (mem_write_data),
    .mem_write_ready    (mem_write_ready),
    .grant_lane         (grant_lane),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Lane-side request state
  bit   [N-1:0]    rd_pend, wr_pend;
  logic [7:0]      rd_addr [N];
  logic [7:0]      wr_addr [N];
  logic [7:0]      wr_data [N];

  // Reference model
  int                m_phase, m_g, m_rr, m_lat, relay_cnt, relay_hold;
  bit                m_is_rd, ready_driven;
  logic [7:0]        m_addr, m_wdata, m_rdata;
  logic [N-1:0][7:0] exp_rdata;
  logic [7:0]        mem_arr [256];

  // Knobs
  int force_lat  = -1;
  int force_hold = -1;
  bit rand_en    = 0;
  bit spurious   = 0;
  bit drop_in_wait = 0;

  // DUT-observed transaction starts: {is_read, grant, address}
  int obs_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) begin
      lane_read_valid[i]    = rd_pend[i];
      lane_write_valid[i]   = wr_pend[i];
      lane_read_address[i]  = rd_addr[i];
      lane_write_address[i] = wr_addr[i];
      lane_write_data[i]    = wr_data[i];
    end
  endtask

  task automatic model_reset();
    m_phase = PhIdle; m_g = 0; m_rr = 0; m_lat = 0; relay_cnt = 0; relay_hold = 0;
    m_is_rd = 0; ready_driven = 0;
    exp_rdata = '0;
    rd_pend = '0; wr_pend = '0;
    mem_read_ready = 0; mem_write_ready = 0; mem_read_data = '0;
    drive_lanes();
  endtask

  // Called once per falling edge: advance the model by what the DUT saw at the rising edge,
  // compare, then drive memory and lane responses for the next rising edge.
  task automatic step();
    bit found;
    int c, g, r;
    found = 0; g = 0;
    case (m_phase)
      PhIdle: begin
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (!found && (rd_pend[c] || wr_pend[c])) begin
            found = 1; g = c;
          end
        end
        if (found) begin
          m_g = g; m_is_rd = rd_pend[g];
          m_addr = m_is_rd ? rd_addr[g] : wr_addr[g];
          m_wdata = wr_data[g];
          m_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
          m_phase = PhWait;
          obs_log.push_back((int'(mem_read_valid) << 12) | (int'(grant_lane) << 8) |
                            int'(mem_read_valid ? mem_read_address : mem_write_address));
        end
      end
      PhWait: begin
        if (ready_driven) begin
          m_phase = PhRelay; relay_cnt = 0;
          relay_hold = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 2));
          if (m_is_rd) exp_rdata[m_g] = m_rdata;
          else mem_arr[m_addr] = m_wdata;
        end
      end
      default: begin
        if (!(m_is_rd ? rd_pend[m_g] : wr_pend[m_g])) begin
          m_phase = PhIdle;
          m_rr = (m_g + 1) % N;
        end
      end
    endcase

    check("busy", busy, m_phase != PhIdle);
    check("mem_read_valid", mem_read_valid, m_phase == PhWait && m_is_rd);
    check("mem_write_valid", mem_write_valid, m_phase == PhWait && !m_is_rd);
    check("grant_lane", grant_lane, m_g);
    if (m_phase == PhWait) begin
      if (m_is_rd) begin
        check("mem_read_address", mem_read_address, m_addr);
      end else begin
        check("mem_write_address", mem_write_address, m_addr);
        check("mem_write_data", mem_write_data, m_wdata);
      end
    end
    check("lane_read_ready", lane_read_ready,
          (m_phase == PhRelay && m_is_rd) ? (64'd1 << m_g) : 64'd0);
    check("lane_write_ready", lane_write_ready,
          (m_phase == PhRelay && !m_is_rd) ? (64'd1 << m_g) : 64'd0);
    check("lane_read_data", lane_read_data, exp_rdata);

    // Memory response, plus ready pulses the DUT must ignore
    mem_read_ready = 0; mem_write_ready = 0; ready_driven = 0;
    mem_read_data = 8'($urandom);
    if (m_phase == PhWait) begin
      if (m_lat == 0) begin
        ready_driven = 1;
        if (m_is_rd) begin
          mem_read_ready = 1; mem_read_data = mem_arr[m_addr]; m_rdata = mem_arr[m_addr];
        end else begin
          mem_write_ready = 1;
        end
      end else begin
        m_lat--;
      end
      if (spurious && $urandom_range(0, 1) == 1) begin
        if (m_is_rd) mem_write_ready = 1;
        else mem_read_ready = 1;
      end
    end else if (spurious) begin
      mem_read_ready  = 1'($urandom_range(0, 1));
      mem_write_ready = 1'($urandom_range(0, 1));
    end

    // Lane behaviour
    if (m_phase == PhRelay) begin
      if (relay_cnt >= relay_hold) begin
        if (m_is_rd) rd_pend[m_g] = 0;
        else wr_pend[m_g] = 0;
      end else begin
        relay_cnt++;
      end
    end
    if (m_phase == PhWait && drop_in_wait) begin
      if (m_is_rd) rd_pend[m_g] = 0;
      else wr_pend[m_g] = 0;
    end
    if (rand_en) begin
      for (int i = 0; i < N; i++) begin
        if (!rd_pend[i] && !wr_pend[i] && !(m_phase != PhIdle && i == m_g) &&
            $urandom_range(0, 3) == 0) begin
          r = int'($urandom_range(0, 2));
          rd_pend[i] = (r != 1);
          wr_pend[i] = (r != 0);
          rd_addr[i] = 8'($urandom_range(0, 15));
          wr_addr[i] = 8'($urandom_range(0, 15));
          wr_data[i] = 8'($urandom);
        end
      end
    end
    drive_lanes();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((m_phase != PhIdle || rd_pend != 0 || wr_pend != 0) && c < 300) begin
      @(negedge clk);
      step();
      c++;
    end
    check(tag, c < 300, 1);
  endtask

  task automatic req_read(input int lane, input logic [7:0] a);
    rd_pend[lane] = 1; rd_addr[lane] = a;
  endtask

  task automatic req_write(input int lane, input logic [7:0] a, input logic [7:0] d);
    wr_pend[lane] = 1; wr_addr[lane] = a; wr_data[lane] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i * 7 + 3);
    for (int i = 0; i < N; i++) begin
      rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0;
    end
    model_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_mem_valids", {mem_read_valid, mem_write_valid}, 0);
    check("reset_lane_ready", {lane_read_ready, lane_write_ready}, 0);
    check("reset_lane_read_data", lane_read_data, 0);
    check("reset_grant", grant_lane, 0);
    @(negedge clk);
    reset = 1;

    // Reset mid-transaction: serve lane1, start lane2 read, reset during READ_WAIT
    mem_arr[5] = 8'h77;
    force_lat = 0; req_read(1, 8'h05); drive_lanes();
    drain("t1_lane1_timeout");
    force_lat = 100; req_read(2, 8'h3C); drive_lanes();
    run(4);
    check("t1_in_read_wait", mem_read_valid, 1);
    @(negedge clk);
    reset = 0;
    #1;
    check("t1_rst_busy", busy, 0);
    check("t1_rst_mem", {mem_read_valid, mem_write_valid, mem_read_address}, 0);
    check("t1_rst_lane", {lane_read_ready, lane_write_ready, grant_lane}, 0);
    check("t1_rst_read_data", lane_read_data, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
    force_lat = -1;
    obs_log.delete();
    req_read(0, 8'h01); req_read(3, 8'h02); drive_lanes();
    drain("t1_after_reset_timeout");
    check("t1_rr_restart_count", obs_log.size(), 2);
    if (obs_log.size() == 2) begin
      check("t1_rr_restart_first", obs_log[0], 32'h1001);
      check("t1_rr_restart_second", obs_log[1], 32'h1302);
    end

    // Single read of 0x3C on lane 2, memory answers after 3 cycles, lane holds valid briefly
    mem_arr[8'h3C] = 8'hA5;
    force_lat = 3; force_hold = 2;
    req_read(2, 8'h3C); drive_lanes();
    drain("t2_timeout");
    check("t2_read_data", lane_read_data[2], 8'hA5);
    force_hold = -1; force_lat = -1;

    // Bring the pointer back to lane 0, then all four lanes write at once
    req_read(3, 8'h00); drive_lanes();
    drain("t3_pre_timeout");
    obs_log.delete();
    for (int i = 0; i < N; i++) req_write(i, 8'(8'h10 + i), 8'(8'h80 + i));
    drive_lanes();
    drain("t3_timeout");
    check("t3_write_count", obs_log.size(), 4);
    for (int i = 0; i < N; i++) begin
      if (i < obs_log.size()) check("t3_write_order", obs_log[i], (i << 8) | (8'h10 + i));
      check("t3_mem_content", mem_arr[8'h10 + i], 8'h80 + i);
    end

    // Round-robin: after lane 1, lanes 0 and 3 contend and lane 3 goes first
    req_read(1, 8'h20); drive_lanes();
    drain("t4_pre_timeout");
    obs_log.delete();
    req_read(0, 8'h21); req_read(3, 8'h22); drive_lanes();
    drain("t4_timeout");
    check("t4_count", obs_log.size(), 2);
    if (obs_log.size() == 2) check("t4_first_lane3", obs_log[0], 32'h1322);

    // Same lane reads and writes: read is issued first
    obs_log.delete();
    req_read(0, 8'h30); req_write(0, 8'h31, 8'h5A); drive_lanes();
    drain("t5_timeout");
    check("t5_count", obs_log.size(), 2);
    if (obs_log.size() == 2) begin
      check("t5_read_first", obs_log[0], 32'h1030);
      check("t5_write_second", obs_log[1], 32'h0031);
    end
    check("t5_mem_content", mem_arr[8'h31], 8'h5A);

    // Spurious memory readies, and a write whose lane drops valid during the wait
    spurious = 1;
    run(6);
    force_lat = 4; drop_in_wait = 1;
    req_write(1, 8'h40, 8'hC3); drive_lanes();
    drain("t6_timeout");
    check("t6_mem_content", mem_arr[8'h40], 8'hC3);
    drop_in_wait = 0; force_lat = -1;

    // Randomized traffic
    rand_en = 1;
    run(2000);
    rand_en = 0;
    drain("random_drain_timeout");
    spurious = 0;
    run(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
